// File: rtl/cache_ctrl.sv
// cache_ctrl: direct-mapped 4x8B write-through cache controller; define CACHE_STATS_EN for hit/miss counters
module cache_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_ready,
  output logic [1:0]        dc_line,
  output logic [2:0]        dc_blk,
  output logic [7:0]        dc_din,
  output logic              dc_wr,
  input  logic [7:0]        dc_dout,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, COMPARE, REFILL, WRITE} state_t;
  state_t state;
  logic we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0] wdata_q;
  logic [2:0] beat;
  logic [3:0] valid;
  logic [ADDR_W-6:0] tags [4];
  logic [ADDR_W-6:0] req_tag;
  logic [1:0] line;
  logic hit, refill, wr_st, busy;
  assign req_tag = addr_q[ADDR_W-1:5];
  assign line    = addr_q[4:3];
  assign hit     = valid[line] && tags[line] == req_tag;
  assign refill  = state == REFILL;
  assign wr_st   = state == WRITE;
  assign busy    = state != IDLE;
  // memory and data-array strobes decoded from the current state
  always_comb begin
    mem_req   = refill || wr_st;
    mem_we    = wr_st;
    mem_addr  = refill ? {req_tag, line, beat} : wr_st ? addr_q : '0;
    mem_wdata = wr_st ? wdata_q : 8'h00;
    dc_line   = busy ? line : 2'd0;
    dc_blk    = refill ? beat : busy ? addr_q[2:0] : 3'd0;
    dc_din    = refill ? mem_rdata : wr_st ? wdata_q : 8'h00;
    dc_wr     = mem_ack && (refill || (wr_st && hit));
  end
  // request sequencing, tag/valid store and CPU response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= 8'h00;
      beat      <= 3'd0;
      valid     <= 4'd0;
      cpu_ready <= 1'b0;
      cpu_rdata <= 8'h00;
      for (int i = 0; i < 4; i++) tags[i] <= '0;
    end else begin
      cpu_ready <= 1'b0;
      case (state)
        IDLE: if (cpu_req) begin
          we_q    <= cpu_we;
          addr_q  <= cpu_addr;
          wdata_q <= cpu_wdata;
          state   <= COMPARE;
        end
        COMPARE: if (we_q) state <= WRITE;
        else if (hit) begin
          cpu_rdata <= dc_dout;
          cpu_ready <= 1'b1;
          state     <= IDLE;
        end else begin
          beat        <= 3'd0;
          valid[line] <= 1'b0;
          state       <= REFILL;
        end
        REFILL: if (mem_ack) begin
          beat <= beat + 3'd1;
          if (beat == 3'd7) begin
            tags[line]  <= req_tag;
            valid[line] <= 1'b1;
            state       <= COMPARE;
          end
        end
        WRITE: if (mem_ack) begin
          cpu_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef CACHE_STATS_EN
  logic refilled;
  // saturating hit/miss counters; the re-compare after a refill is not a new request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= 16'd0;
      miss_cnt <= 16'd0;
      refilled <= 1'b0;
    end else if (refill && mem_ack && beat == 3'd7) refilled <= 1'b1;
    else if (state == COMPARE) begin
      refilled <= 1'b0;
      if (!refilled && hit && !(&hit_cnt)) hit_cnt <= hit_cnt + 16'd1;
      if (!refilled && !hit && !(&miss_cnt)) miss_cnt <= miss_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: directed + random bench with memory/data-array models and a line-level cache model
module tb_cache_ctrl;
  logic clk = 1'b0, rst_n = 1'b1, cpu_req = 1'b0, cpu_we = 1'b0;
  logic [7:0] cpu_addr = 8'h00, cpu_wdata = 8'h00, cpu_rdata;
  logic cpu_ready, dc_wr, mem_req, mem_we, mem_ack = 1'b0;
  logic [1:0] dc_line;
  logic [2:0] dc_blk;
  logic [7:0] dc_din, dc_dout, mem_addr, mem_wdata, mem_rdata;
`ifdef CACHE_STATS_EN
  logic [15:0] hit_cnt, miss_cnt;
  int hc = 0, mc = 0;
`endif
  int checks = 0, errors = 0;
  bit fast = 1'b1;
  logic [7:0] mem [256];
  logic [7:0] arr [32];
  logic [7:0] mref [256];
  bit vld [4];
  logic [2:0] tg [4];
  logic [7:0] rd_q [$];
  logic [7:0] wr_a [$];
  logic [7:0] wr_d [$];

  cache_ctrl #(.ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .dc_line(dc_line), .dc_blk(dc_blk), .dc_din(dc_din), .dc_wr(dc_wr), .dc_dout(dc_dout),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef CACHE_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_addr];
  assign dc_dout   = arr[{dc_line, dc_blk}];

  // memory acks decided away from the active edge; zero-wait when fast is set
  always @(negedge clk) mem_ack = mem_req && (fast || $urandom_range(0, 2) != 0);

  // backing memory and data array storage, plus a log of memory beats
  always @(posedge clk) begin
    if (dc_wr) arr[{dc_line, dc_blk}] <= dc_din;
    if (mem_req && mem_ack) begin
      if (mem_we) begin
        mem[mem_addr] <= mem_wdata;
        wr_a.push_back(mem_addr);
        wr_d.push_back(mem_wdata);
      end else rd_q.push_back(mem_addr);
    end
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic chk_stats();
`ifdef CACHE_STATS_EN
    chk("hit_cnt", 32'(hit_cnt), 32'(hc));
    chk("miss_cnt", 32'(miss_cnt), 32'(mc));
`endif
  endtask

  task automatic chk_idle_outputs();
    chk("rst_ready", 32'(cpu_ready), 0);
    chk("rst_rdata", 32'(cpu_rdata), 0);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", 32'(mem_wdata), 0);
    chk("rst_dc_wr", 32'(dc_wr), 0);
    chk("rst_dc_sel", 32'({dc_line, dc_blk, dc_din}), 0);
  endtask

  task automatic xact(input bit we, input logic [7:0] a, input logic [7:0] d);
    int edges;
    bit hit;
    logic [1:0] l;
    l = a[4:3];
    hit = vld[l] && tg[l] == a[7:5];
    rd_q.delete(); wr_a.delete(); wr_d.delete();
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    cpu_req = 1'b0; cpu_we = 1'($urandom); cpu_addr = 8'($urandom); cpu_wdata = 8'($urandom);
    while (!cpu_ready && edges < 300) begin
      @(negedge clk);
      edges++;
    end
    chk("ready", 32'(cpu_ready), 1);
    if (we) begin
      chk("wr_beats", 32'(wr_a.size()), 1);
      if (wr_a.size() == 1) begin
        chk("wr_addr", 32'(wr_a[0]), 32'(a));
        chk("wr_data", 32'(wr_d[0]), 32'(d));
      end
      chk("wr_no_rd", 32'(rd_q.size()), 0);
      if (fast) chk("wr_latency", 32'(edges), 3);
      mref[a] = d;
`ifdef CACHE_STATS_EN
      if (hit) hc++; else mc++;
`endif
    end else begin
      chk("rdata", 32'(cpu_rdata), 32'(mref[a]));
      chk("rd_beats", 32'(rd_q.size()), hit ? 0 : 8);
      chk("rd_no_wr", 32'(wr_a.size()), 0);
      if (!hit) for (int i = 0; i < rd_q.size() && i < 8; i++)
        chk("beat_addr", 32'(rd_q[i]), 32'({a[7:3], 3'(i)}));
      if (hit) chk("hit_latency", 32'(edges), 2);
      else if (fast) chk("miss_latency", 32'(edges), 11);
      vld[l] = 1'b1;
      tg[l] = a[7:5];
`ifdef CACHE_STATS_EN
      if (hit) hc++; else mc++;
`endif
    end
    @(negedge clk);
    chk("ready_pulse", 32'(cpu_ready), 0);
    chk_stats();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'(i) ^ 8'h5A;
      mref[i] = 8'(i) ^ 8'h5A;
    end
    for (int i = 0; i < 32; i++) arr[i] = 8'h00;
    for (int i = 0; i < 4; i++) vld[i] = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle_outputs();
    chk_stats();
    rst_n = 1'b1;
    // directed scenarios with zero-wait memory
    xact(1'b0, 8'h2B, 8'h00);
    chk("first_rdata", 32'(cpu_rdata), 32'h71);
    xact(1'b0, 8'h2D, 8'h00);
    chk("hit_rdata", 32'(cpu_rdata), 32'h77);
    xact(1'b1, 8'h2D, 8'hC3);
    xact(1'b0, 8'h2D, 8'h00);
    chk("wr_hit_rdata", 32'(cpu_rdata), 32'hC3);
    xact(1'b1, 8'hE0, 8'h11);
    xact(1'b0, 8'hE0, 8'h00);
    xact(1'b0, 8'h08, 8'h00);
    xact(1'b0, 8'h48, 8'h00);
    xact(1'b0, 8'h08, 8'h00);
    // reset in the middle of a refill
    rd_q.delete();
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h93;
    @(negedge clk);
    cpu_req = 1'b0;
    n = 0;
    while (rd_q.size() < 4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("partial_beats", 32'(rd_q.size()), 4);
    rst_n = 1'b0;
    #1;
    chk_idle_outputs();
    for (int i = 0; i < 4; i++) vld[i] = 1'b0;
`ifdef CACHE_STATS_EN
    hc = 0;
    mc = 0;
`endif
    chk_stats();
    @(negedge clk);
    rst_n = 1'b1;
    xact(1'b0, 8'h93, 8'h00);
    xact(1'b0, 8'h2B, 8'h00);
    // randomized traffic with random memory wait states
    fast = 1'b0;
    repeat (60) xact($urandom_range(0, 2) == 0, 8'($urandom_range(0, 127)), 8'($urandom));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
